// File: rtl/sfp_vec3_dot_seq_if.sv
// Operand/result handshake bundle for the sequential 3-element fixed-point
// dot product. The master side presents operands and consumes results; the
// slave side is the compute block.
interface sfp_vec3_dot_seq_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a [3];
  logic [W-1:0] b [3];
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         clipping;
  logic         busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, clipping, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out, clipping, busy
  );
endinterface

// File: rtl/sfp_vec3_dot_seq.sv
// Sequential signed fixed-point dot product of two 3-element vectors.
// One shared W x W multiplier is stepped across the elements; the full
// 2W+2-bit sum is shifted back to Q(IW).(QW) once and saturated to W bits.
module sfp_vec3_dot_seq #(
  parameter int IW = 16,
  parameter int QW = 16
) (
  input logic               clk,
  input logic               rst,
  sfp_vec3_dot_seq_if.slave bus
);
  localparam int W  = IW + QW;
  localparam int AW = 2 * W + 2;

  // Saturation bounds, sign-extended to accumulator width.
  localparam logic signed [AW-1:0] SAT_MAX = {{(W + 3){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(W + 3){1'b1}}, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [1:0]            idx;
  logic signed [W-1:0]   a_r [3];
  logic signed [W-1:0]   b_r [3];
  logic signed [W-1:0]   op_a;
  logic signed [W-1:0]   op_b;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  acc_sum;
  logic signed [AW-1:0]  res;
  logic [W-1:0]          out_r;
  logic                  clip_r;
  logic                  accept;
  logic                  last;

  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (state == MAC) && (idx == 2'd2);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  // NOTE: the default assignment first keeps this block free of latches
  // on any path the case statement does not cover.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nx = MAC;
      MAC:     if (idx == 2'd2)   state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  // Operand select for the single shared multiplier.
  always_comb begin
    op_a = a_r[0];
    op_b = b_r[0];
    case (idx)
      2'd1: begin op_a = a_r[1]; op_b = b_r[1]; end
      2'd2: begin op_a = a_r[2]; op_b = b_r[2]; end
      default: ;
    endcase
  end

  assign prod    = (2 * W)'(op_a) * (2 * W)'(op_b);
  assign acc_sum = acc + AW'(prod);
  assign res     = acc_sum >>> QW;

  // Capture operands at acceptance so later input changes cannot disturb
  // the in-flight result.
  // NOTE: pure data registers carry no reset; they are always written before
  // being read, which keeps the reset tree off this wide datapath.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        a_r[i] <= $signed(bus.a[i]);
        b_r[i] <= $signed(bus.b[i]);
      end
    end
  end

  // Accumulate, step the element index and register the saturated result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= 2'd0;
      acc    <= '0;
      out_r  <= '0;
      clip_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc <= '0;
            idx <= 2'd0;
          end
        end
        MAC: begin
          acc <= acc_sum;
          idx <= last ? 2'd0 : idx + 2'd1;
          if (last) begin
            if (res > SAT_MAX) begin
              out_r  <= SAT_MAX[W-1:0];
              clip_r <= 1'b1;
            end else if (res < SAT_MIN) begin
              out_r  <= SAT_MIN[W-1:0];
              clip_r <= 1'b1;
            end else begin
              out_r  <= res[W-1:0];
              clip_r <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out       = out_r;
  assign bus.clipping  = clip_r;
endmodule

// File: doc/sfp_vec3_dot_seq.md
SFP_VEC3_DOT_SEQ -- requirements
Module: sfp_vec3_dot_seq

Interface
REQ-001 Parameter IW, default 16: integer bits of the signed fixed-point format.
REQ-002 Parameter QW, default 16: fractional bits; word width W = IW+QW (32 by default).
REQ-003 Port clk  input  1: single clock, all state updates on rising edge.
REQ-004 Port rst  input  1: asynchronous reset, active-high.
REQ-005 Port in_valid  input  1: operand pair a/b presented.
REQ-006 Port in_ready  output  1: block accepts operands this cycle.
REQ-007 Port a  input  W x 3 (unpacked [3]): vector A, signed Q(IW).(QW) two's complement.
REQ-008 Port b  input  W x 3 (unpacked [3]): vector B, same format.
REQ-009 Port out_valid  output  1: result available.
REQ-010 Port out_ready  input  1: consumer takes result.
REQ-011 Port out  output  W: dot product A.B, same format.
REQ-012 Port clipping  output  1: result saturated, qualified by out_valid.
REQ-013 Port busy  output  1: high whenever state is not IDLE.

Function
REQ-014 Time-multiplexed: exactly one signed W x W multiplier instance, shared across the three element products.
REQ-015 FSM states IDLE, MAC, DONE; 2-bit element index idx.
REQ-016 in_ready = 1 iff state == IDLE; out_valid = 1 iff state == DONE (both decoded from registered state).
REQ-017 IDLE, in_valid && in_ready: register a[0..2], b[0..2]; clear accumulator; idx <= 0; go to MAC.
REQ-018 MAC: each cycle acc <= acc + a_r[idx]*b_r[idx] (full 2W-bit product, sign-extended); idx increments.
REQ-019 MAC with idx == 2: after final accumulate, register out/clipping from final sum, go to DONE.
REQ-020 Latency: handshake on edge k -> out_valid high in the cycle after edge k+3; throughput one result per 5 cycles minimum.
REQ-021 Accumulator width 2W+2 bits; no intermediate truncation or overflow.
REQ-022 Result r = acc >>> QW (arithmetic shift, floor rounding toward -inf), computed once on the full sum.
REQ-023 If r > 2^(W-1)-1: out = 2^(W-1)-1, clipping = 1; if r < -2^(W-1): out = -2^(W-1), clipping = 1; else out = r[W-1:0], clipping = 0.
REQ-024 DONE: out/clipping held stable until out_valid && out_ready; then go to IDLE.
REQ-025 No new operands accepted in the DONE cycle even when out_ready = 1 (in_ready = 0 in DONE).
REQ-026 Input a/b changes after acceptance have no effect on the in-flight result.
REQ-027 in_valid while not IDLE is ignored; no queueing.

Reset
REQ-028 rst asserted: state = IDLE, idx = 0, acc = 0, out = 0, clipping = 0 immediately, independent of clk.
REQ-029 Reset outputs: in_ready = 1 after deassertion, out_valid = 0, busy = 0.
REQ-030 rst during MAC or DONE aborts the operation; partial result is discarded, never presented.

Verification
REQ-031 a = {0x00010000,0x00020000,0x00030000}, b = {0x00040000,0x00050000,0x00060000}, out_ready = 1 -> out = 0x00200000 (32.0), clipping = 0, out_valid exactly 4 cycles after accept edge.
REQ-032 a = {0xFFFF0000,0,0}, b = {0x00008000,0,0} -> out = 0xFFFF8000 (-0.5), clipping = 0; a = {0xFFFFFFFF,0,0}, b = {0x00000001,0,0} -> out = 0xFFFFFFFF (floor), clipping = 0.
REQ-033 a = b = {0x7FFF0000 x3} -> out = 0x7FFFFFFF, clipping = 1; a = {0x7FFF0000 x3}, b = {0x80000000 x3} -> out = 0x80000000, clipping = 1.
REQ-034 Backpressure: out_ready = 0 for 6 cycles after out_valid -> out/clipping stable, in_ready = 0, in_valid pulses ignored; out_ready = 1 -> IDLE next cycle, in_ready = 1.
REQ-035 rst pulse mid-MAC (idx = 1) -> outputs reset asynchronously, no out_valid for aborted op; next op a = {0x00010000,0,0}, b = {0x00010000,0,0} -> out = 0x00010000.
REQ-036 Back-to-back: in_valid held high with two operand sets, out_ready = 1 -> two correct results, accept edges exactly 5 cycles apart.
